// File: rtl/stack_read_sequencer.sv
// +------------------------------------------------------------------------+
// | stack_read_sequencer                                                   |
// | Single-read and paced/back-to-back repeat-read strobe sequencer.       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module stack_read_sequencer #(
  parameter int DATA_WIDTH  = 4,
  parameter int TICK_PERIOD = 100000000,
  parameter int CNT_WIDTH   = 27
) (
  input  logic                  clk,
  input  logic                  rst_edge,
  input  logic                  pop_edge,
  input  logic                  read_more_edge,
  input  logic                  abort,
  input  logic                  mode,
  input  logic                  stack_empty,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  citaj,
  output logic                  citaj_vise,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow,
  output logic [DATA_WIDTH-1:0] remaining
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  TICK_LAST = CNT_WIDTH'(TICK_PERIOD - 1);
  localparam logic [DATA_WIDTH-1:0] REM_ONE   = DATA_WIDTH'(1);

  state_t                  state, state_n;
  logic [CNT_WIDTH-1:0]    cnt, cnt_n;
  logic                    mode_l, mode_n;
  logic [DATA_WIDTH-1:0]   rem_n;
  logic                    citaj_n, citaj_vise_n, done_n, underflow_n;
  logic                    tick, fire;

  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge) begin
      state      <= IDLE;
      cnt        <= '0;
      mode_l     <= 1'b0;
      remaining  <= '0;
      citaj      <= 1'b0;
      citaj_vise <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      mode_l     <= mode_n;
      remaining  <= rem_n;
      citaj      <= citaj_n;
      citaj_vise <= citaj_vise_n;
      busy       <= (state_n == RUN);
      done       <= done_n;
      underflow  <= underflow_n;
    end
  end

  // Branch order encodes the priority abort > read_more > pop > tick/fire.
  always_comb begin
    state_n      = state;
    cnt_n        = '0;
    mode_n       = mode_l;
    rem_n        = remaining;
    citaj_n      = 1'b0;
    citaj_vise_n = 1'b0;
    done_n       = 1'b0;
    underflow_n  = 1'b0;
    tick         = (cnt == TICK_LAST);
    fire         = 1'b0;

    if (abort) begin
      if (state == RUN) begin
        state_n = IDLE;
        rem_n   = '0;
      end
    end else if (read_more_edge) begin
      if (stack_empty) begin
        underflow_n = 1'b1;
        state_n     = IDLE;
        rem_n       = '0;
      end else begin
        rem_n  = data_in;
        mode_n = mode;
        if (data_in == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
    end else if (pop_edge && (state == IDLE)) begin
      if (stack_empty) underflow_n = 1'b1;
      else             citaj_n     = 1'b1;
    end else if (state == RUN) begin
      fire  = mode_l | tick;
      cnt_n = tick ? '0 : cnt + 1'b1;
      if (fire) begin
        if (stack_empty) begin
          underflow_n = 1'b1;
          state_n     = IDLE;
          rem_n       = '0;
          cnt_n       = '0;
        end else if (remaining != '0) begin
          citaj_vise_n = 1'b1;
          rem_n        = remaining - 1'b1;
          if (remaining == REM_ONE) begin
            done_n  = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_read_sequencer.sv
// +------------------------------------------------------------------------+
// | tb_stack_read_sequencer                                                |
// | Directed self-checking bench for stack_read_sequencer, TICK_PERIOD=4.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_stack_read_sequencer;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_edge = 1'b1;
  logic          pop_edge = 1'b0;
  logic          read_more_edge = 1'b0;
  logic          abort = 1'b0;
  logic          mode = 1'b0;
  logic          stack_empty = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          citaj, citaj_vise, busy, done, underflow;
  logic [DW-1:0] remaining;

  int vectors = 0;
  int miscompares = 0;
  int strobes;

  stack_read_sequencer #(
    .DATA_WIDTH (DW),
    .TICK_PERIOD(4),
    .CNT_WIDTH  (2)
  ) dut (
    .clk           (clk),
    .rst_edge      (rst_edge),
    .pop_edge      (pop_edge),
    .read_more_edge(read_more_edge),
    .abort         (abort),
    .mode          (mode),
    .stack_empty   (stack_empty),
    .data_in       (data_in),
    .citaj         (citaj),
    .citaj_vise    (citaj_vise),
    .busy          (busy),
    .done          (done),
    .underflow     (underflow),
    .remaining     (remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then reflect that edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [DW-1:0] n, input logic m);
    data_in        = n;
    mode           = m;
    read_more_edge = 1'b1;
    cyc();
    read_more_edge = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".citaj"}, {7'd0, citaj}, 8'd0);
    chk({tag, ".citaj_vise"}, {7'd0, citaj_vise}, 8'd0);
    chk({tag, ".busy"}, {7'd0, busy}, 8'd0);
    chk({tag, ".done"}, {7'd0, done}, 8'd0);
    chk({tag, ".underflow"}, {7'd0, underflow}, 8'd0);
    chk({tag, ".remaining"}, {4'd0, remaining}, 8'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    chk_all_zero("reset");
    rst_edge = 1'b0;
    cyc();

    // Single pop, stack not empty
    pop_edge = 1'b1; cyc(); pop_edge = 1'b0;
    chk("pop.citaj", {7'd0, citaj}, 8'd1);
    chk("pop.uf", {7'd0, underflow}, 8'd0);
    cyc();
    chk("pop.citaj_end", {7'd0, citaj}, 8'd0);

    // Pop on empty stack
    stack_empty = 1'b1;
    pop_edge = 1'b1; cyc(); pop_edge = 1'b0;
    chk("pop_empty.uf", {7'd0, underflow}, 8'd1);
    chk("pop_empty.citaj", {7'd0, citaj}, 8'd0);
    cyc();
    chk("pop_empty.uf_end", {7'd0, underflow}, 8'd0);

    // read_more on empty stack
    start_seq(4'd3, 1'b1);
    chk("rm_empty.uf", {7'd0, underflow}, 8'd1);
    chk("rm_empty.busy", {7'd0, busy}, 8'd0);
    stack_empty = 1'b0;
    cyc();

    // Back-to-back, N=3
    start_seq(4'd3, 1'b1);
    chk("b2b.E0.busy", {7'd0, busy}, 8'd1);
    chk("b2b.E0.rem", {4'd0, remaining}, 8'd3);
    chk("b2b.E0.cv", {7'd0, citaj_vise}, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk($sformatf("b2b.E%0d.cv", k), {7'd0, citaj_vise}, 8'd1);
      chk($sformatf("b2b.E%0d.rem", k), {4'd0, remaining}, 8'(3 - k));
      chk($sformatf("b2b.E%0d.done", k), {7'd0, done}, (k == 3) ? 8'd1 : 8'd0);
      chk($sformatf("b2b.E%0d.busy", k), {7'd0, busy}, (k == 3) ? 8'd0 : 8'd1);
    end
    cyc();
    chk("b2b.after.cv", {7'd0, citaj_vise}, 8'd0);
    chk("b2b.after.done", {7'd0, done}, 8'd0);

    // Paced, N=2, pop mid-sequence ignored
    start_seq(4'd2, 1'b0);
    chk("paced.E0.rem", {4'd0, remaining}, 8'd2);
    for (int k = 1; k <= 8; k++) begin
      pop_edge = (k == 2);
      cyc();
      pop_edge = 1'b0;
      chk($sformatf("paced.E%0d.cv", k), {7'd0, citaj_vise}, (k % 4 == 0) ? 8'd1 : 8'd0);
      chk($sformatf("paced.E%0d.citaj", k), {7'd0, citaj}, 8'd0);
      chk($sformatf("paced.E%0d.done", k), {7'd0, done}, (k == 8) ? 8'd1 : 8'd0);
    end
    chk("paced.end.busy", {7'd0, busy}, 8'd0);
    chk("paced.end.rem", {4'd0, remaining}, 8'd0);

    // Paced N=5, stack empties before second tick
    start_seq(4'd5, 1'b0);
    strobes = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (citaj_vise) strobes++;
      if (k == 4) stack_empty = 1'b1;
    end
    chk("cut.strobes", 8'(strobes), 8'd1);
    chk("cut.uf", {7'd0, underflow}, 8'd1);
    chk("cut.done", {7'd0, done}, 8'd0);
    chk("cut.busy", {7'd0, busy}, 8'd0);
    chk("cut.rem", {4'd0, remaining}, 8'd0);
    stack_empty = 1'b0;
    cyc();
    chk("cut.uf_end", {7'd0, underflow}, 8'd0);

    // Abort after first strobe
    start_seq(4'd4, 1'b1);
    cyc();
    chk("abort.first_cv", {7'd0, citaj_vise}, 8'd1);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("abort.cv", {7'd0, citaj_vise}, 8'd0);
    chk("abort.busy", {7'd0, busy}, 8'd0);
    chk("abort.rem", {4'd0, remaining}, 8'd0);
    chk("abort.done", {7'd0, done}, 8'd0);
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (citaj_vise || done) strobes++;
    end
    chk("abort.quiet", 8'(strobes), 8'd0);

    // Restart mid-run: N=4 paced, new read_more N=2 two cycles after first strobe
    start_seq(4'd4, 1'b0);
    repeat (4) cyc();
    chk("restart.first_cv", {7'd0, citaj_vise}, 8'd1);
    chk("restart.first_rem", {4'd0, remaining}, 8'd3);
    cyc();
    start_seq(4'd2, 1'b0);
    chk("restart.rem", {4'd0, remaining}, 8'd2);
    chk("restart.busy", {7'd0, busy}, 8'd1);
    strobes = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (citaj_vise) strobes++;
      chk($sformatf("restart.E%0d.cv", k), {7'd0, citaj_vise},
          (k == 4 || k == 8) ? 8'd1 : 8'd0);
    end
    chk("restart.strobes", 8'(strobes), 8'd2);

    // Zero-length sequence
    start_seq(4'd0, 1'b1);
    chk("zero.done", {7'd0, done}, 8'd1);
    chk("zero.busy", {7'd0, busy}, 8'd0);
    chk("zero.cv", {7'd0, citaj_vise}, 8'd0);
    cyc();
    chk("zero.done_end", {7'd0, done}, 8'd0);
    chk("zero.cv_end", {7'd0, citaj_vise}, 8'd0);

    // Asynchronous reset mid-sequence
    start_seq(4'd3, 1'b1);
    cyc();
    #2 rst_edge = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) cyc();
    rst_edge = 1'b0;
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (citaj_vise || busy || done) strobes++;
    end
    chk("rst_mid.quiet", 8'(strobes), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
